sdram_rr_arbiter: RTL and testbench
===================================

// Module: sdram_rr_arbiter
// PURPOSE
//  Shares one 32-bit toggle-handshake SDRAM read port (gfx/port2-style req/ack) between
//  NUM_CLIENTS read-only requesters, e.g. tilemap/sprite fetchers in the video path.
//  Round-robin grant, one transaction outstanding at a time, plus a one-entry last-word
//  cache that answers repeated address reads without touching SDRAM.
// PARAMETERS
//  NUM_CLIENTS  4   number of requesters (2..8)
//  AW           22  word address width (client/SDRAM address is [AW:1])
//  DW           32  data width returned by the SDRAM port
//  HIT_EN       1   1 = enable last-word cache short-circuit, 0 = always go to SDRAM
// PORTS
//  clk       in   1               system/SDRAM clock, all logic on posedge
//  init_n    in   1               asynchronous active-low reset
//  flush     in   1               invalidate last-word cache (ROM download, bank switch)
//  cl_req    in   NUM_CLIENTS     per-client request toggle
//  cl_ack    out  NUM_CLIENTS     per-client ack toggle; pending while cl_req[i]!=cl_ack[i]
//  cl_addr   in   NUM_CLIENTS*AW  client i address at [i*AW +: AW], stable while pending
//  cl_q      out  NUM_CLIENTS*DW  client i data at [i*DW +: DW], valid when ack==req
//  mem_req   out  1               toggle to SDRAM port
//  mem_ack   in   1               toggle from SDRAM port; done when mem_ack==mem_req
//  mem_addr  out  AW              SDRAM word address, held through transaction
//  mem_q     in   DW              SDRAM data, sampled in cycle mem_ack==mem_req seen
// BEHAVIOUR
//  Reset (init_n low, async): cl_ack=0, cl_q=0, mem_req=0, mem_addr=0, rr_ptr=0,
//   cache valid=0, state=IDLE. Reset mid-transaction abandons it; SDRAM ctrl shares init_n.
//  States: IDLE, WAIT, RESP.
//  IDLE: pending = cl_req ^ cl_ack. Pick first pending client searching rr_ptr,
//   rr_ptr+1, ... wrapping mod NUM_CLIENTS -> grant g; latch g and cl_req[g] (req_tag).
//   Hit (HIT_EN & valid & cl_addr[g]==last_addr & !flush): latch last_q, -> RESP.
//   Miss: mem_addr<=cl_addr[g], mem_req<=~mem_req, -> WAIT. No pending: stay IDLE.
//  WAIT: when mem_ack==mem_req: last_addr<=mem_addr, last_q<=mem_q, data<=mem_q,
//   valid<=~flush_seen; -> RESP. Otherwise hold; mem_addr/mem_req never change in WAIT.
//  RESP: cl_q[g]<=data, cl_ack[g]<=req_tag, rr_ptr<=(g+1) mod NUM_CLIENTS, -> IDLE.
//   Only client g's q/ack change; other cl_q hold their last value.
//  Latency from pending visible in IDLE: hit -> ack toggles 2 clk later;
//   miss -> ack toggles 2 clk after cycle mem_ack==mem_req is sampled.
//  Throughput: one grant per IDLE visit; IDLE is at least 1 cycle between grants.
//  flush: clears valid at next edge in any state; flush during WAIT sets flush_seen so
//   the returning word is delivered to the client but not cached; flush_seen clears in IDLE.
//  Simultaneous pending: strict round-robin; a just-served client is lowest priority next.
//  Client re-toggling req before its ack is a protocol violation; arbiter acks with the
//   req value latched at grant (req_tag), leaving the client pending again.
//  Address compare is full AW bits; last_addr/last_q not reset-cleared beyond valid=0.
//  mem_ack toggling while not in WAIT is ignored (no state change).
// TESTING
//  Single client 0 req toggle addr 0x001234, mem_ack returns 3 clk later with 0xDEADBEEF
//   -> mem_addr=0x001234, one mem_req toggle, cl_q[0]=0xDEADBEEF, cl_ack[0]=1.
//  Clients 0..3 all pending at once, rr_ptr=0 -> grant order 0,1,2,3; then client 0 and 2
//   pending with rr_ptr=0 after serving 3 -> order 0,2.
//  Client 1 reads 0x000100 twice (HIT_EN=1) -> second ack 2 clk after pending, no
//   mem_req toggle, same data; with HIT_EN=0 -> second mem_req toggle issued.
//  Flush asserted during WAIT for 0x000200 -> client gets data; repeat read of 0x000200
//   -> new SDRAM access (cache miss).
//  init_n pulsed low while in WAIT -> all outputs 0, state IDLE; pending client is re-served
//   after release with correct ack polarity.
//  Random soak: 4 clients, random addresses/delays vs. reference model -> every ack paired
//   with correct data, no starvation (max wait <= NUM_CLIENTS grants).

Source files
------------

// File: rtl/sdram_rr_arbiter_if.sv
// rtl/sdram_rr_arbiter_if.sv - client request/ack bus and SDRAM read port of the round-robin arbiter
interface sdram_rr_arbiter_if #(
    parameter int NUM_CLIENTS = 4,
    parameter int AW          = 22,
    parameter int DW          = 32
);
    // Cache invalidate strobe (ROM download, bank switch)
    logic                      flush;

    // Client side: one toggle-handshake slot per requester
    logic [NUM_CLIENTS-1:0]    cl_req;
    logic [NUM_CLIENTS-1:0]    cl_ack;
    logic [NUM_CLIENTS*AW-1:0] cl_addr;
    logic [NUM_CLIENTS*DW-1:0] cl_q;

    // SDRAM side: single toggle-handshake read port
    logic                      mem_req;
    logic                      mem_ack;
    logic [AW-1:0]             mem_addr;
    logic [DW-1:0]             mem_q;

    // Arbiter view: serves clients, drives the SDRAM port
    modport master (
        input  flush,
        input  cl_req,
        input  cl_addr,
        output cl_ack,
        output cl_q,
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_q
    );

    // Environment view: clients plus SDRAM controller
    modport slave (
        output flush,
        output cl_req,
        output cl_addr,
        input  cl_ack,
        input  cl_q,
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_q
    );
endinterface

// File: rtl/sdram_rr_arbiter.sv
// rtl/sdram_rr_arbiter.sv - round-robin sharing of one toggle-handshake SDRAM read port with a last-word cache
module sdram_rr_arbiter #(
    parameter int NUM_CLIENTS = 4,
    parameter int AW          = 22,
    parameter int DW          = 32,
    parameter int HIT_EN      = 1
) (
    input  logic                clk,
    input  logic                init_n,
    sdram_rr_arbiter_if.master  bus
);

    localparam int IW   = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
    localparam int IDXW = IW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                    state;
    state_t                    state_nxt;

    logic [IW-1:0]             rr_ptr;
    logic [IW-1:0]             grant;
    logic [IW-1:0]             pick;
    logic [IDXW-1:0]           idx;
    logic                      any_pending;
    logic [NUM_CLIENTS-1:0]    pending;
    logic [AW-1:0]             sel_addr;
    logic                      hit;
    logic                      mem_done;

    logic                      req_tag;
    logic [DW-1:0]             data_r;
    logic [AW-1:0]             last_addr;
    logic [DW-1:0]             last_q;
    logic                      valid;
    logic                      flush_seen;

    logic                      mem_req_r;
    logic [AW-1:0]             mem_addr_r;
    logic [NUM_CLIENTS-1:0]    cl_ack_r;
    logic [NUM_CLIENTS*DW-1:0] cl_q_r;

    assign bus.mem_req  = mem_req_r;
    assign bus.mem_addr = mem_addr_r;
    assign bus.cl_ack   = cl_ack_r;
    assign bus.cl_q     = cl_q_r;

    // Round-robin pick: scan from rr_ptr upward with wrap; lowest offset wins,
    // so the client just served (rr_ptr-1) is considered last.
    always_comb begin
        pending     = bus.cl_req ^ cl_ack_r;
        pick        = '0;
        any_pending = 1'b0;
        idx         = '0;
        for (int k = NUM_CLIENTS - 1; k >= 0; k--) begin
            idx = {1'b0, rr_ptr} + IDXW'(k);
            if (idx >= IDXW'(NUM_CLIENTS)) begin
                idx = idx - IDXW'(NUM_CLIENTS);
            end
            if (pending[idx[IW-1:0]]) begin
                pick        = idx[IW-1:0];
                any_pending = 1'b1;
            end
        end
    end

    // Cache lookup for the chosen client and SDRAM completion detect.
    // A flush in the same cycle forces a miss so stale data is never served.
    always_comb begin
        sel_addr = bus.cl_addr[int'(pick)*AW +: AW];
        hit      = (HIT_EN != 0) && valid && (sel_addr == last_addr) && !bus.flush;
        mem_done = (bus.mem_ack == mem_req_r);
    end

    // FSM state register
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state: grant from IDLE, wait for SDRAM on a miss, answer in RESP
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (any_pending) begin
                    state_nxt = hit ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_done) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Grant bookkeeping: remember who was granted and the req level to echo back
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            grant   <= '0;
            req_tag <= 1'b0;
        end else if (state == S_IDLE && any_pending) begin
            grant   <= pick;
            req_tag <= bus.cl_req[pick];
        end
    end

    // SDRAM request: toggle once per miss, address held until the next miss
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            mem_req_r  <= 1'b0;
            mem_addr_r <= '0;
        end else if (state == S_IDLE && any_pending && !hit) begin
            mem_req_r  <= ~mem_req_r;
            mem_addr_r <= sel_addr;
        end
    end

    // Response word: cached word on a hit, SDRAM word on completion
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            data_r <= '0;
        end else if (state == S_IDLE && any_pending && hit) begin
            data_r <= last_q;
        end else if (state == S_WAIT && mem_done) begin
            data_r <= bus.mem_q;
        end
    end

    // Last-word cache contents; only the valid bit is cleared by reset
    always_ff @(posedge clk) begin
        if (state == S_WAIT && mem_done) begin
            last_addr <= mem_addr_r;
            last_q    <= bus.mem_q;
        end
    end

    // Cache valid: flush wins in any state; a word fetched across a flush is not kept
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            valid <= 1'b0;
        end else if (bus.flush) begin
            valid <= 1'b0;
        end else if (state == S_WAIT && mem_done) begin
            valid <= ~flush_seen;
        end
    end

    // Remember a flush that arrived while the SDRAM access was in flight
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            flush_seen <= 1'b0;
        end else if (state == S_IDLE) begin
            flush_seen <= 1'b0;
        end else if (state == S_WAIT && bus.flush) begin
            flush_seen <= 1'b1;
        end
    end

    // Deliver to the granted client only, then rotate priority past it
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            cl_q_r   <= '0;
            cl_ack_r <= '0;
            rr_ptr   <= '0;
        end else if (state == S_RESP) begin
            cl_q_r[int'(grant)*DW +: DW] <= data_r;
            cl_ack_r[grant]              <= req_tag;
            rr_ptr                       <= (grant == IW'(NUM_CLIENTS - 1)) ? '0 : grant + 1'b1;
        end
    end

endmodule

// File: tb/tb_sdram_rr_arbiter.sv
// tb/tb_sdram_rr_arbiter.sv - scoreboard bench for sdram_rr_arbiter
module tb_sdram_rr_arbiter;

    localparam int NC = 4;
    localparam int AW = 22;
    localparam int DW = 32;

    logic clk    = 1'b0;
    logic init_n = 1'b0;

    always #5 clk = ~clk;

    sdram_rr_arbiter_if #(.NUM_CLIENTS(NC), .AW(AW), .DW(DW)) bus  ();
    sdram_rr_arbiter_if #(.NUM_CLIENTS(NC), .AW(AW), .DW(DW)) bus2 ();

    sdram_rr_arbiter #(.NUM_CLIENTS(NC), .AW(AW), .DW(DW), .HIT_EN(1)) dut (
        .clk    (clk),
        .init_n (init_n),
        .bus    (bus)
    );

    sdram_rr_arbiter #(.NUM_CLIENTS(NC), .AW(AW), .DW(DW), .HIT_EN(0)) u_nohit (
        .clk    (clk),
        .init_n (init_n),
        .bus    (bus2)
    );

    assign bus2.cl_req  = bus.cl_req;
    assign bus2.cl_addr = bus.cl_addr;
    assign bus2.flush   = bus.flush;

    typedef struct {
        int            cli;
        logic          tag;
        logic [DW-1:0] q;
        int            req_cyc;
        int            mark;
    } exp_t;

    exp_t            exp_q[$];
    int              served[$];
    int              lat[NC];
    logic [NC-1:0]   busy = '0;
    logic [NC-1:0]   prev_ack;
    int              n_err = 0;
    int              n_chk = 0;
    int              cyc = 0;
    int              acks = 0;
    int              mem_cnt = 0;
    int              mem2_cnt = 0;
    int              mem_delay = 3;
    logic [AW-1:0]   mem_addr_seen = '0;
    int              m0;
    int              m2;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
        if (a == 22'h001234) return 32'hDEADBEEF;
        return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input int c, input logic [AW-1:0] a);
        exp_t e;
        bus.cl_addr[c*AW +: AW] = a;
        bus.cl_req[c]           = ~bus.cl_req[c];
        e.cli     = c;
        e.tag     = bus.cl_req[c];
        e.q       = mem_f(a);
        e.req_cyc = cyc;
        e.mark    = acks;
        exp_q.push_back(e);
        busy[c] = 1'b1;
    endtask

    task automatic wait_idle(input string tag, input int max_cyc);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_outstanding"}, 64'(exp_q.size()), 64'd0);
        if (exp_q.size() != 0) begin
            exp_q.delete();
            busy = '0;
        end
    endtask

    task automatic wait_nohit(input string tag, input int max_cyc);
        int n;
        n = 0;
        while (bus2.cl_ack !== bus.cl_req && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_nohit_settled"}, 64'(bus2.cl_ack), 64'(bus.cl_req));
    endtask

    // SDRAM model for the HIT_EN=1 arbiter: answers after mem_delay cycles
    initial begin : mem1
        int cnt;
        cnt         = -1;
        bus.mem_ack = 1'b0;
        bus.mem_q   = '0;
        forever begin
            @(negedge clk);
            if (!init_n) begin
                bus.mem_ack = 1'b0;
                cnt         = -1;
            end else if (bus.mem_req !== bus.mem_ack) begin
                if (cnt < 0) cnt = mem_delay - 1;
                if (cnt == 0) begin
                    mem_addr_seen = bus.mem_addr;
                    bus.mem_q     = mem_f(bus.mem_addr);
                    bus.mem_ack   = bus.mem_req;
                    cnt           = -1;
                    mem_cnt++;
                end else begin
                    cnt--;
                end
            end
        end
    end

    // SDRAM model for the HIT_EN=0 arbiter: answers at the first negedge
    initial begin : mem2
        bus2.mem_ack = 1'b0;
        bus2.mem_q   = '0;
        forever begin
            @(negedge clk);
            if (!init_n) begin
                bus2.mem_ack = 1'b0;
            end else if (bus2.mem_req !== bus2.mem_ack) begin
                bus2.mem_q   = mem_f(bus2.mem_addr);
                bus2.mem_ack = bus2.mem_req;
                mem2_cnt++;
            end
        end
    end

    // Scoreboard: every ack toggle must match an outstanding request of that client
    initial begin : mon
        int idx;
        prev_ack = '0;
        forever begin
            @(negedge clk);
            if (!init_n) begin
                prev_ack = bus.cl_ack;
            end else begin
                for (int i = 0; i < NC; i++) begin
                    if (bus.cl_ack[i] !== prev_ack[i]) begin
                        idx = -1;
                        for (int j = 0; j < exp_q.size(); j++) begin
                            if (exp_q[j].cli == i && idx < 0) idx = j;
                        end
                        served.push_back(i);
                        chk($sformatf("ack_expected_c%0d", i), 64'(idx >= 0), 64'd1);
                        if (idx >= 0) begin
                            chk($sformatf("ack_polarity_c%0d", i), 64'(bus.cl_ack[i]), 64'(exp_q[idx].tag));
                            chk($sformatf("ack_data_c%0d", i), 64'(bus.cl_q[i*DW +: DW]), 64'(exp_q[idx].q));
                            chk($sformatf("starvation_c%0d", i), 64'((acks - exp_q[idx].mark) <= NC), 64'd1);
                            lat[i] = cyc - exp_q[idx].req_cyc;
                            exp_q.delete(idx);
                            busy[i] = 1'b0;
                        end
                        acks++;
                    end
                end
                prev_ack = bus.cl_ack;
            end
        end
    end

    initial begin : stim
        logic [AW-1:0] a;
        bus.cl_req  = '0;
        bus.cl_addr = '0;
        bus.flush   = 1'b0;
        init_n      = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_cl_ack",   64'(bus.cl_ack),      64'd0);
        chk("rst_mem_req",  64'(bus.mem_req),     64'd0);
        chk("rst_mem_addr", 64'(bus.mem_addr),    64'd0);
        chk("rst_cl_q_lo",  bus.cl_q[63:0],       64'd0);
        chk("rst_cl_q_hi",  bus.cl_q[127:64],     64'd0);
        #2 init_n = 1'b1;

        // Single miss through SDRAM with a 3-cycle response
        mem_delay = 3;
        @(negedge clk);
        m0 = mem_cnt;
        send(0, 22'h001234);
        wait_idle("t1", 50);
        chk("t1_mem_addr",     64'(mem_addr_seen),   64'h001234);
        chk("t1_mem_toggles",  64'(mem_cnt - m0),    64'd1);
        chk("t1_cl_q0",        64'(bus.cl_q[31:0]),  64'hDEADBEEF);
        chk("t1_cl_ack0",      64'(bus.cl_ack[0]),   64'd1);
        chk("t1_miss_latency", 64'(lat[0]),          64'd5);
        chk("t1_mem_req",      64'(bus.mem_req),     64'd1);

        // Serve client 3 so the pointer wraps to 0, then all four at once
        mem_delay = 2;
        @(negedge clk);
        send(3, 22'h000040);
        wait_idle("t2_pre", 50);
        served.delete();
        @(negedge clk);
        for (int c = 0; c < NC; c++) send(c, AW'(22'h000300 + c));
        wait_idle("t2a", 200);
        chk("t2a_count", 64'(served.size()), 64'd4);
        for (int k = 0; k < 4; k++)
            chk($sformatf("t2a_order_%0d", k), 64'(served.size() > k ? served[k] : -1), 64'(k));
        served.delete();
        @(negedge clk);
        send(2, 22'h000402);
        send(0, 22'h000400);
        wait_idle("t2b", 100);
        chk("t2b_order_0", 64'(served.size() > 0 ? served[0] : -1), 64'd0);
        chk("t2b_order_1", 64'(served.size() > 1 ? served[1] : -1), 64'd2);

        // Repeat read hits the cache; the HIT_EN=0 instance goes to SDRAM twice
        wait_nohit("t3_pre", 200);
        m0 = mem_cnt;
        m2 = mem2_cnt;
        @(negedge clk);
        send(1, 22'h000100);
        wait_idle("t3a", 50);
        wait_nohit("t3a", 50);
        @(negedge clk);
        send(1, 22'h000100);
        wait_idle("t3b", 50);
        chk("t3_hit_latency",    64'(lat[1]),               64'd2);
        chk("t3_mem_toggles",    64'(mem_cnt - m0),         64'd1);
        wait_nohit("t3b", 50);
        chk("t3_nohit_toggles",  64'(mem2_cnt - m2),        64'd2);
        chk("t3_nohit_q1",       64'(bus2.cl_q[63:32]),     64'(mem_f(22'h000100)));

        // Same low bits, top address bit differs: must miss
        m0 = mem_cnt;
        @(negedge clk);
        send(1, 22'h200100);
        wait_idle("t3c", 50);
        chk("t3_full_compare_miss", 64'(mem_cnt - m0), 64'd1);

        // Flush during WAIT: word delivered but not cached
        mem_delay = 4;
        m0 = mem_cnt;
        @(negedge clk);
        send(0, 22'h000200);
        repeat (2) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        wait_idle("t4a", 50);
        chk("t4_first_access", 64'(mem_cnt - m0), 64'd1);
        @(negedge clk);
        send(2, 22'h000200);
        wait_idle("t4b", 50);
        chk("t4_refetch_after_flush", 64'(mem_cnt - m0), 64'd2);

        // Reset while waiting on SDRAM; client 2 is re-served after release
        mem_delay = 10;
        @(negedge clk);
        send(2, 22'h000500);
        repeat (3) @(negedge clk);
        #2 init_n = 1'b0;
        @(negedge clk);
        chk("t5_cl_ack",   64'(bus.cl_ack),   64'd0);
        chk("t5_mem_req",  64'(bus.mem_req),  64'd0);
        chk("t5_mem_addr", 64'(bus.mem_addr), 64'd0);
        chk("t5_cl_q_lo",  bus.cl_q[63:0],    64'd0);
        chk("t5_cl_q_hi",  bus.cl_q[127:64],  64'd0);
        exp_q.delete();
        busy        = '0;
        bus.cl_req  = '0;
        send(2, 22'h000500);
        mem_delay   = 2;
        #2 init_n = 1'b1;
        wait_idle("t5", 50);
        chk("t5_ack_polarity", 64'(bus.cl_ack), 64'b0100);

        // Random soak with address reuse, random latency and occasional flush
        for (int it = 0; it < 600; it++) begin
            @(negedge clk);
            mem_delay = $urandom_range(1, 5);
            bus.flush = ($urandom_range(0, 19) == 0);
            for (int c = 0; c < NC; c++) begin
                if (!busy[c] && $urandom_range(0, 3) == 0) begin
                    a = AW'($urandom_range(0, 5));
                    if ($urandom_range(0, 1) == 1) a[AW-1] = 1'b1;
                    send(c, a);
                end
            end
        end
        bus.flush = 1'b0;
        wait_idle("soak", 500);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
